// File: rtl/uart_pkg.sv
// Shared UART constants and receiver/transmitter state encodings.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT = 868;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned DATA_W       = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO on a register array.
// A pop when full frees the slot the simultaneous push lands in.
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (ADDR_W+1)'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_fifoed_recv.sv
// 8N1 UART receiver with centre-of-bit sampling feeding a FWFT receive FIFO.
// Flags framing errors (1-cycle pulse) and FIFO overrun (sticky until reset).
module uart_fifoed_recv #(
  parameter int unsigned CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned ADDR_W       = 4
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       RX,
  input  logic       rd_en,
  output logic [7:0] dat,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       frame_err,
  output logic       overrun
);

  import uart_pkg::*;

  localparam int unsigned HALF_CLKS = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitn_q, bitn_d;
  logic [7:0]       shift_q, shift_d;
  logic             sync1_q, sync1_d;
  logic             rx_s_q, rx_s_d;
  logic             push_q, push_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic [ADDR_W:0]  fifo_count;
  logic             fifo_at_cap;

  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign fifo_at_cap = (fifo_count == (ADDR_W+1)'(FIFO_DEPTH));

  // Bit-timing FSM; decisions are taken only on the synchronised line rx_s.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitn_d      = bitn_q;
    shift_d     = shift_q;
    sync1_d     = RX;
    rx_s_d      = sync1_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    // A push into a full FIFO is dropped unless a pop frees a slot that cycle.
    overrun_d   = overrun_q | (push_q & fifo_at_cap & ~rd_en);

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = CNT_W'(HALF_CLKS - 1);
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!rx_s_q) begin
            state_d = DATA;
            cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
            bitn_d  = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
          if (bitn_q == 3'd7) state_d = STOP;
          else                bitn_d  = bitn_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (rx_s_q) begin
            push_d  = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BRK;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      BRK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitn_q      <= '0;
      shift_q     <= '0;
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitn_q      <= bitn_d;
      shift_q     <= shift_d;
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_fifo (
    .clk   (clk_100MHz),
    .reset (reset),
    .push  (push_q),
    .pop   (rd_en),
    .din   (shift_q),
    .dout  (dat),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_uart_fifoed_recv.sv
// Randomised bench for uart_fifoed_recv against a byte-level queue model.
module tb_uart_fifoed_recv;

  localparam int unsigned C     = 32;
  localparam int unsigned H     = C / 2;
  localparam int unsigned DEPTH = 16;
  // Cycles from driving the start edge to the edge that writes the FIFO:
  // 2 sync flops + detect + half bit + 9 bits + registered push.
  localparam int WR_LAT = 4 + H + 9 * C;

  logic       clk_100MHz = 1'b0;
  logic       reset = 1'b1;
  logic       RX = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] dat;
  logic       fifo_empty, fifo_full, frame_err, overrun;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int exp_fe = 0;
  int clash_cnt = 0;
  int force_pop_cyc = -1;
  bit reader_on = 1'b0;
  bit exp_ovr = 1'b0;
  byte unsigned exp_q[$];

  uart_fifoed_recv #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (DEPTH),
    .ADDR_W       (4)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .RX         (RX),
    .rd_en      (rd_en),
    .dat        (dat),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk_100MHz = ~clk_100MHz;
  always @(posedge clk_100MHz) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_100MHz) begin
    if (frame_err) fe_cnt++;
    if (frame_err && overrun) clash_cnt++;
  end

  // Reader: random pops while enabled, plus a forced pop on a chosen cycle.
  always @(negedge clk_100MHz) begin
    bit want;
    want = (reader_on && !fifo_empty && ($urandom_range(0, 2) != 0)) || (cyc == force_pop_cyc);
    rd_en = want;
    if (want && !fifo_empty) begin
      if (exp_q.size() == 0) check_eq("pop_unexpected", 32'd1, 32'd0);
      else check_eq("pop_dat", 32'(dat), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_100MHz);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] data, input bit stop_ok, input int bclk,
                           input bit chk_lat, input bit pop_at_push);
    int t0, n, j;
    n = stop_ok ? 10 * bclk : 11 * bclk;
    if (n <= WR_LAT) n = WR_LAT + 1;
    @(posedge clk_100MHz);
    #1;
    t0 = cyc;
    if (pop_at_push) force_pop_cyc = t0 + WR_LAT - 1;
    for (int i = 0; i < n; i++) begin
      j = i / bclk;
      if (j == 0)      RX = 1'b0;
      else if (j <= 8) RX = data[j-1];
      else             RX = stop_ok;
      if (chk_lat && i == WR_LAT - 1) check_eq("empty_before_push", 32'(fifo_empty), 32'd1);
      if (i == WR_LAT) begin
        if (chk_lat) check_eq("empty_after_push", 32'(fifo_empty), 32'd0);
        if (stop_ok) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(data);
          else exp_ovr = 1'b1;
        end
      end
      tick(1);
    end
    RX = 1'b1;
    if (!stop_ok) exp_fe++;
  endtask

  task automatic do_reset();
    reader_on     = 1'b0;
    force_pop_cyc = -1;
    reset         = 1'b1;
    RX            = 1'b1;
    tick(3);
    reset = 1'b0;
    exp_q.delete();
    exp_ovr = 1'b0;
    check_eq("rst_dat", 32'(dat), 32'd0);
    check_eq("rst_empty", 32'(fifo_empty), 32'd1);
    check_eq("rst_full", 32'(fifo_full), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    reader_on = 1'b1;
    while ((exp_q.size() != 0 || !fifo_empty) && k < 4000) begin
      tick(1);
      k++;
    end
    reader_on = 1'b0;
    check_eq({tag, "_empty"}, 32'(fifo_empty), 32'd1);
    check_eq({tag, "_model_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] b2;
    do_reset();

    // Single byte with exact push latency, then one pop.
    send_byte(8'hA5, 1'b1, C, 1'b1, 1'b0);
    check_eq("t1_dat", 32'(dat), 32'hA5);
    force_pop_cyc = cyc;
    tick(1);
    check_eq("t1_empty_after_pop", 32'(fifo_empty), 32'd1);

    // Short low glitch is rejected.
    RX = 1'b0;
    tick(H / 2);
    RX = 1'b1;
    tick(2 * C);
    check_eq("t2_empty", 32'(fifo_empty), 32'd1);
    check_eq("t2_no_frame_err", 32'(fe_cnt), 32'd0);

    // Bad stop held low for two bits, then a good byte.
    send_byte(8'h3C, 1'b0, C, 1'b0, 1'b0);
    tick(C);
    check_eq("t3_frame_err_pulse", 32'(fe_cnt), 32'd1);
    check_eq("t3_empty", 32'(fifo_empty), 32'd1);
    send_byte(8'h11, 1'b1, C, 1'b0, 1'b0);
    check_eq("t3_dat", 32'(dat), 32'h11);
    wait_drain("t3");

    // Pop coinciding with push into an empty FIFO: push kept, pop ignored.
    b = 8'($urandom);
    send_byte(b, 1'b1, C, 1'b0, 1'b1);
    check_eq("t5_empty_pop_push", 32'(fifo_empty), 32'd0);
    check_eq("t5_empty_pop_dat", 32'(dat), 32'(b));
    // Pop coinciding with push at count 1: head replaced by the new byte.
    b2 = 8'($urandom);
    send_byte(b2, 1'b1, C, 1'b0, 1'b1);
    check_eq("t5_cnt1_nonempty", 32'(fifo_empty), 32'd0);
    check_eq("t5_cnt1_dat", 32'(dat), 32'(b2));
    // Back-to-back stream with line rate skewed by about +-3%.
    reader_on = 1'b1;
    for (int k = 0; k < 24; k++) begin
      send_byte(8'($urandom), 1'b1, C - 1 + $urandom_range(0, 2), 1'b0, 1'b0);
    end
    wait_drain("t5");
    check_eq("t5_overrun", 32'(overrun), 32'd0);

    // Seventeen bytes without reads: full after 16, overrun on the 17th.
    for (int k = 0; k < 17; k++) begin
      send_byte(8'(k), 1'b1, C, 1'b0, 1'b0);
      if (k == 15) begin
        check_eq("t4_full16", 32'(fifo_full), 32'd1);
        check_eq("t4_no_ovr16", 32'(overrun), 32'd0);
      end
    end
    check_eq("t4_overrun", 32'(overrun), 32'd1);
    check_eq("t4_model_ovr", 32'(overrun), 32'(exp_ovr));
    check_eq("t4_full17", 32'(fifo_full), 32'd1);
    wait_drain("t4");
    check_eq("t4_overrun_sticky", 32'(overrun), 32'd1);

    // Pop coinciding with push at full: no overrun, FIFO stays full.
    do_reset();
    for (int k = 0; k < 16; k++) send_byte(8'($urandom), 1'b1, C, 1'b0, 1'b0);
    check_eq("tf_full", 32'(fifo_full), 32'd1);
    send_byte(8'($urandom), 1'b1, C, 1'b0, 1'b1);
    check_eq("tf_no_overrun", 32'(overrun), 32'd0);
    check_eq("tf_still_full", 32'(fifo_full), 32'd1);
    wait_drain("tf");

    // Reset in the middle of 0x5A's data bits, then 0x81.
    b = 8'h5A;
    RX = 1'b0;
    tick(C);
    for (int k = 0; k < 3; k++) begin
      RX = b[k];
      tick(C);
    end
    do_reset();
    tick(2 * C);
    check_eq("t6_empty_after_abort", 32'(fifo_empty), 32'd1);
    send_byte(8'h81, 1'b1, C, 1'b0, 1'b0);
    check_eq("t6_dat", 32'(dat), 32'h81);
    wait_drain("t6");

    check_eq("frame_err_total", 32'(fe_cnt), 32'(exp_fe));
    check_eq("fe_ovr_same_cycle", 32'(clash_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
